// File: rtl/dcache_data_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : dcache_data_pkg                                         |
// | Brief    : Geometry, types and helpers shared by the dcache data   |
// |            array front-end (40x128 1R1W macro).                    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
package dcache_data_pkg;

  localparam int DEPTH = 40;
  localparam int WIDTH = 128;
  localparam int AW    = 6;

  typedef logic [AW-1:0]    addr_t;
  typedef logic [WIDTH-1:0] data_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Highest valid row; anything above it is out of range.
  localparam addr_t c_last_row = addr_t'(DEPTH - 1);

  // Full-width compare: no folding of addresses beyond the last row.
  function automatic logic addr_in_range(input addr_t a);
    return (a <= c_last_row);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rr_arbiter                                              |
// | Brief    : N-way round-robin arbiter, combinational one-hot grant, |
// |            search starts at the stored pointer.                    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] r_ptr_q;
  logic [IW-1:0] w_ptr_d;
  logic          w_found;
  int            w_idx;

  // First requester at or after the pointer (wrapping) wins the grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(r_ptr_q) + k) % N;
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IW'(w_idx);
      end
    end
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_comb begin
    w_ptr_d = r_ptr_q;
    if (w_found) begin
      w_ptr_d = (int'(gnt_idx) + 1 == N) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) r_ptr_q <= '0;
    else       r_ptr_q <= w_ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/dcache_data_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : dcache_data_arbiter                                     |
// | Brief    : Front-end for the 40x128 1R1W data macro: zero-fills    |
// |            all rows after reset, then round-robins NR readers and  |
// |            NW writers onto the single read / write ports, with a   |
// |            write-first bypass for same-cycle same-row collisions.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dcache_data_arbiter
  import dcache_data_pkg::*;
#(
  parameter int NR = 2,
  parameter int NW = 2,
  localparam int IDW = (NR > 1) ? $clog2(NR) : 1,
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                clock,
  input  logic                reset,
  // read requesters
  input  logic [NR-1:0]       rd_valid,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR-1:0]       rd_ready,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [WIDTH-1:0]    rsp_data,
  output logic                rsp_err,
  // write requesters
  input  logic [NW-1:0]       wr_valid,
  input  logic [NW*AW-1:0]    wr_addr,
  input  logic [NW*WIDTH-1:0] wr_data,
  output logic [NW-1:0]       wr_ready,
  output logic                init_done,
  // macro ports
  output logic [AW-1:0]       R0_addr,
  output logic                R0_en,
  input  logic [WIDTH-1:0]    R0_data,
  output logic [AW-1:0]       W0_addr,
  output logic                W0_en,
  output logic [WIDTH-1:0]    W0_data
);

  state_e         r_state_q, w_state_d;
  addr_t          r_init_cnt_q, w_init_cnt_d;

  logic           r_rsp_valid_q, w_rsp_valid_d;
  logic [IDW-1:0] r_rsp_id_q, w_rsp_id_d;
  logic           r_rsp_err_q, w_rsp_err_d;
  logic           r_byp_hit_q, w_byp_hit_d;
  data_t          r_byp_data_q, w_byp_data_d;

  logic           w_run;
  logic [IDW-1:0] w_rd_idx;
  logic [WIW-1:0] w_wr_idx;
  logic           w_rd_fire, w_wr_fire;
  addr_t          w_rd_addr, w_wr_addr;
  data_t          w_wr_data;
  logic           w_rd_in_range, w_wr_in_range;
  logic           w_collide;

  assign w_run = (r_state_q == RUN);

  rr_arbiter #(.N(NR)) u_rd_arb (
    .clock   (clock),
    .reset   (reset),
    .en      (w_run),
    .req     (rd_valid),
    .gnt     (rd_ready),
    .gnt_idx (w_rd_idx)
  );

  rr_arbiter #(.N(NW)) u_wr_arb (
    .clock   (clock),
    .reset   (reset),
    .en      (w_run),
    .req     (wr_valid),
    .gnt     (wr_ready),
    .gnt_idx (w_wr_idx)
  );

  assign w_rd_fire     = |rd_ready;
  assign w_wr_fire     = |wr_ready;
  assign w_rd_addr     = rd_addr[int'(w_rd_idx)*AW +: AW];
  assign w_wr_addr     = wr_addr[int'(w_wr_idx)*AW +: AW];
  assign w_wr_data     = wr_data[int'(w_wr_idx)*WIDTH +: WIDTH];
  assign w_rd_in_range = addr_in_range(w_rd_addr);
  assign w_wr_in_range = addr_in_range(w_wr_addr);
  // Out-of-range reads never touch the macro, so they cannot collide.
  assign w_collide     = w_rd_fire && w_wr_fire && w_rd_in_range &&
                         (w_rd_addr == w_wr_addr);

  // State and init-counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q    <= INIT;
      r_init_cnt_q <= '0;
    end else begin
      r_state_q    <= w_state_d;
      r_init_cnt_q <= w_init_cnt_d;
    end
  end

  // INIT walks every row once, then RUN holds until the next reset.
  always_comb begin
    w_state_d    = r_state_q;
    w_init_cnt_d = r_init_cnt_q;
    case (r_state_q)
      INIT: begin
        if (r_init_cnt_q == c_last_row) w_state_d    = RUN;
        else                            w_init_cnt_d = r_init_cnt_q + 1'b1;
      end
      RUN:     w_state_d = RUN;
      default: w_state_d = INIT;
    endcase
  end

  // Macro port drive: zero-fill during INIT, granted requests during RUN.
  always_comb begin
    R0_en   = 1'b0;
    R0_addr = '0;
    W0_en   = 1'b0;
    W0_addr = '0;
    W0_data = '0;
    if (r_state_q == INIT) begin
      W0_en   = 1'b1;
      W0_addr = r_init_cnt_q;
    end else begin
      if (w_rd_fire) begin
        R0_addr = w_rd_addr;
        R0_en   = w_rd_in_range;
      end
      if (w_wr_fire) begin
        W0_addr = w_wr_addr;
        W0_data = w_wr_data;
        W0_en   = w_wr_in_range;
      end
    end
  end

  assign init_done = w_run;

  // Response stage inputs; idle fields are forced to zero.
  always_comb begin
    w_rsp_valid_d = w_rd_fire;
    w_rsp_id_d    = w_rd_fire ? w_rd_idx : '0;
    w_rsp_err_d   = w_rd_fire && !w_rd_in_range;
    w_byp_hit_d   = w_collide;
    w_byp_data_d  = w_collide ? w_wr_data : '0;
  end

  // Response pipeline registers; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_valid_q <= 1'b0;
      r_rsp_id_q    <= '0;
      r_rsp_err_q   <= 1'b0;
      r_byp_hit_q   <= 1'b0;
      r_byp_data_q  <= '0;
    end else begin
      r_rsp_valid_q <= w_rsp_valid_d;
      r_rsp_id_q    <= w_rsp_id_d;
      r_rsp_err_q   <= w_rsp_err_d;
      r_byp_hit_q   <= w_byp_hit_d;
      r_byp_data_q  <= w_byp_data_d;
    end
  end

  assign rsp_valid = r_rsp_valid_q;
  assign rsp_id    = r_rsp_id_q;
  assign rsp_err   = r_rsp_err_q;

  // Response data: zero on error/idle, bypass on collision, else macro output.
  always_comb begin
    rsp_data = '0;
    if (r_rsp_valid_q && !r_rsp_err_q) begin
      rsp_data = r_byp_hit_q ? r_byp_data_q : R0_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_data_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_dcache_data_arbiter                                  |
// | Brief    : Directed self-checking bench for dcache_data_arbiter    |
// |            with a behavioural 1R1W macro model.                    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_dcache_data_arbiter;
  import dcache_data_pkg::*;

  logic               clock;
  logic               reset;
  logic [1:0]         rd_valid;
  logic [2*AW-1:0]    rd_addr;
  logic [1:0]         rd_ready;
  logic               rsp_valid;
  logic [0:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;
  logic [1:0]         wr_valid;
  logic [2*AW-1:0]    wr_addr;
  logic [2*WIDTH-1:0] wr_data;
  logic [1:0]         wr_ready;
  logic               init_done;
  logic [AW-1:0]      R0_addr;
  logic               R0_en;
  logic [WIDTH-1:0]   R0_data;
  logic [AW-1:0]      W0_addr;
  logic               W0_en;
  logic [WIDTH-1:0]   W0_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [WIDTH-1:0] c_a5 = {16{8'hA5}};
  localparam logic [WIDTH-1:0] c_5a = {16{8'h5A}};
  localparam logic [WIDTH-1:0] c_1234 = 128'h1234;

  dcache_data_arbiter #(.NR(2), .NW(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .init_done (init_done),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data)
  );

  // Macro model: registered read returning the pre-write contents.
  logic [WIDTH-1:0] mem [0:63];
  logic [WIDTH-1:0] r0_q;
  always @(posedge clock) begin
    if (W0_en) mem[W0_addr] <= W0_data;
    if (R0_en) r0_q <= mem[R0_addr];
  end
  assign R0_data = r0_q;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Walk n INIT cycles expecting zero-fill rows 0..n-1 and no grants.
  task automatic init_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      #1;
      chk("init_w0_en",   W0_en,     1);
      chk("init_w0_addr", W0_addr,   c);
      chk("init_w0_data", W0_data,   0);
      chk("init_rd_rdy",  rd_ready,  0);
      chk("init_wr_rdy",  wr_ready,  0);
      chk("init_done_lo", init_done, 0);
      tick();
    end
  endtask

  initial begin
    reset    = 1'b1;
    rd_valid = '0;
    rd_addr  = '0;
    wr_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    tick();
    tick();

    // reset values
    chk("rst_rd_ready",  rd_ready,  0);
    chk("rst_wr_ready",  wr_ready,  0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err",   rsp_err,   0);
    chk("rst_init_done", init_done, 0);
    chk("rst_r0_en",     R0_en,     0);
    reset = 1'b0;

    // initialisation: exactly 40 zero-fill writes, then RUN
    init_cycles(40);
    #1;
    chk("run_init_done", init_done, 1);
    chk("run_w0_idle",   W0_en,     0);

    // every row reads back as zero, back-to-back on requester 0
    for (int r = 0; r < DEPTH; r++) begin
      rd_valid = 2'b01;
      rd_addr  = {6'd0, 6'(r)};
      #1;
      chk("scan_rd_ready", rd_ready, 2'b01);
      chk("scan_r0_en",    R0_en,    1);
      tick();
      chk("scan_rsp_valid", rsp_valid, 1);
      chk("scan_rsp_data",  rsp_data,  0);
    end
    // requester 1 alone, leaving the read pointer at 0
    rd_valid = 2'b10;
    rd_addr  = {6'd0, 6'd0};
    #1;
    chk("solo1_rd_ready", rd_ready, 2'b10);
    tick();
    rd_valid = 2'b00;
    chk("solo1_rsp_id", rsp_id, 1);

    // round robin with both requesting: 0,1,0,1
    rd_valid = 2'b11;
    rd_addr  = {6'd5, 6'd3};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rd_ready", rd_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id",    rsp_id,    i % 2);
      chk("rr_rsp_data",  rsp_data,  0);
    end
    rd_valid = 2'b00;
    tick();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rsp_id",    rsp_id,    0);
    chk("idle_rsp_data",  rsp_data,  0);

    // collision on row 7: write-first via bypass
    wr_valid = 2'b01;
    wr_addr  = {6'd0, 6'd7};
    wr_data  = {128'd0, c_a5};
    rd_valid = 2'b01;
    rd_addr  = {6'd0, 6'd7};
    #1;
    chk("col_wr_ready", wr_ready, 2'b01);
    chk("col_rd_ready", rd_ready, 2'b01);
    chk("col_w0_en",    W0_en,    1);
    chk("col_w0_addr",  W0_addr,  7);
    chk("col_w0_data",  W0_data,  c_a5);
    chk("col_r0_en",    R0_en,    1);
    tick();
    wr_valid = 2'b00;
    wr_data  = '0;
    chk("col_rsp_valid", rsp_valid, 1);
    chk("col_rsp_data",  rsp_data,  c_a5);
    #1;
    chk("col2_rd_ready", rd_ready, 2'b01);
    tick();
    rd_valid = 2'b00;
    chk("col2_rsp_data", rsp_data, c_a5);

    // out of range: read 45 on requester 0, write 63 on requester 1
    rd_valid = 2'b01;
    rd_addr  = {6'd0, 6'd45};
    wr_valid = 2'b10;
    wr_addr  = {6'd63, 6'd0};
    wr_data  = {c_5a, 128'd0};
    #1;
    chk("oor_rd_ready", rd_ready, 2'b01);
    chk("oor_r0_en",    R0_en,    0);
    chk("oor_wr_ready", wr_ready, 2'b10);
    chk("oor_w0_en",    W0_en,    0);
    tick();
    rd_valid = 2'b00;
    wr_valid = 2'b00;
    chk("oor_rsp_valid", rsp_valid, 1);
    chk("oor_rsp_err",   rsp_err,   1);
    chk("oor_rsp_data",  rsp_data,  0);
    chk("oor_rsp_id",    rsp_id,    0);
    tick();
    chk("oor_idle_valid", rsp_valid, 0);
    chk("oor_idle_err",   rsp_err,   0);

    // boundary rows: 39 is writable/readable, 40 is out of range
    wr_valid = 2'b01;
    wr_addr  = {6'd0, 6'd39};
    wr_data  = {128'd0, c_5a};
    #1;
    chk("b39_w0_en",   W0_en,   1);
    chk("b39_w0_addr", W0_addr, 39);
    tick();
    wr_valid = 2'b00;
    rd_valid = 2'b01;
    rd_addr  = {6'd0, 6'd39};
    #1;
    chk("b39_r0_en", R0_en, 1);
    tick();
    chk("b39_rsp_data", rsp_data, c_5a);
    chk("b39_rsp_err",  rsp_err,  0);
    rd_addr = {6'd0, 6'd40};
    #1;
    chk("b40_r0_en", R0_en, 0);
    tick();
    rd_valid = 2'b00;
    chk("b40_rsp_err",  rsp_err,  1);
    chk("b40_rsp_data", rsp_data, 0);

    // reset in RUN with a read in flight
    rd_valid = 2'b01;
    rd_addr  = {6'd0, 6'd7};
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    chk("rrun_rsp_valid", rsp_valid, 0);
    chk("rrun_init_done", init_done, 0);

    // requests held throughout INIT; reset again at init_cnt 20
    rd_valid = 2'b11;
    rd_addr  = {6'd3, 6'd10};
    wr_valid = 2'b11;
    wr_addr  = {6'd3, 6'd10};
    wr_data  = {c_5a, c_1234};
    init_cycles(20);
    #1;
    chk("mid_w0_addr", W0_addr, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    init_cycles(40);

    // first RUN cycle grants immediately from pointer 0 on both sides
    #1;
    chk("first_init_done", init_done, 1);
    chk("first_rd_ready",  rd_ready,  2'b01);
    chk("first_wr_ready",  wr_ready,  2'b01);
    chk("first_w0_en",     W0_en,     1);
    chk("first_w0_addr",   W0_addr,   10);
    chk("first_w0_data",   W0_data,   c_1234);
    chk("first_r0_en",     R0_en,     1);
    tick();
    rd_valid = 2'b00;
    wr_valid = 2'b00;
    chk("first_rsp_valid", rsp_valid, 1);
    chk("first_rsp_id",    rsp_id,    0);
    chk("first_rsp_data",  rsp_data,  c_1234);
    tick();
    chk("end_rsp_valid", rsp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
